hazard_ctrl_unit: RTL



---
 rtl/hazard_ctrl_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: latch enables, flushes, PC write
// enable, operand forwarding selects and stall/freeze statistics.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   ihit, dhit        fetch / data access complete
//   mem_memop         MEM stage holds a load or store
//   id_valid, id_rs   ID instruction valid and its packed sources
//   ex_src            EX packed sources (forwarding compare)
//   ex_regwr/memread  EX writes a register / is a load
//   ex_wsel           EX destination
//   mem_regwr/memread MEM writes a register / is a load
//   mem_wsel          MEM destination
//   wb_regwr, wb_wsel WB write enable and destination
//   redirect          taken branch/jump resolved in EX
//   pc_wen .. memwb_en latch enables
//   ifid/idex_flush   latch flushes
//   fwd_sel           2 bits per slot: 00 rf, 01 WB, 10 MEM
//   stall_cnt         saturating count of load-use bubbles
//   freeze_cnt        saturating count of freeze cycles
module hazard_ctrl_unit #(
  parameter int REGW          = 5,
  parameter int NSRC          = 2,
  parameter int LDUSE_BUBBLES = 1,
  parameter int FLUSH_CYCLES  = 1,
  parameter int CNTW          = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_memop,
  input  logic              id_valid,
  input  logic [NSRC*REGW-1:0] id_rs,
  input  logic [NSRC*REGW-1:0] ex_src,
  input  logic              ex_regwr,
  input  logic              ex_memread,
  input  logic [REGW-1:0]   ex_wsel,
  input  logic              mem_regwr,
  input  logic              mem_memread,
  input  logic [REGW-1:0]   mem_wsel,
  input  logic              wb_regwr,
  input  logic [REGW-1:0]   wb_wsel,
  input  logic              redirect,
  output logic              pc_wen,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [NSRC*2-1:0] fwd_sel,
  output logic [CNTW-1:0]   stall_cnt,
  output logic [CNTW-1:0]   freeze_cnt
);

  localparam int MAXC =
    (LDUSE_BUBBLES > FLUSH_CYCLES) ?
    LDUSE_BUBBLES : FLUSH_CYCLES;
  localparam int CW = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_LDSTALL = 2'd1;
  localparam logic [1:0] S_FLUSH   = 2'd2;

  localparam logic [CW-1:0] LB_LOAD =
    CW'(LDUSE_BUBBLES - 1);
  localparam logic [CW-1:0] FL_LOAD =
    CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          freeze;
  logic          luse;
  logic          stall_inc;
  logic [REGW-1:0] src;
  logic          rs_hit;

  assign freeze = !ihit | (mem_memop & !dhit);

  // A load sitting in MEM has no data yet, so it is
  // skipped here; its value is picked up from WB later.
  always_comb begin
    fwd_sel = '0;
    src     = '0;
    for (int i = 0; i < NSRC; i++) begin
      src = ex_src[i*REGW +: REGW];
      if (mem_regwr && !mem_memread &&
          mem_wsel != '0 && mem_wsel == src)
        fwd_sel[i*2 +: 2] = 2'b10;
      else if (wb_regwr && wb_wsel != '0 &&
               wb_wsel == src)
        fwd_sel[i*2 +: 2] = 2'b01;
      else
        fwd_sel[i*2 +: 2] = 2'b00;
    end
    if (RST)
      fwd_sel = '0;
  end

  always_comb begin
    rs_hit = 1'b0;
    for (int i = 0; i < NSRC; i++)
      if (id_rs[i*REGW +: REGW] == ex_wsel)
        rs_hit = 1'b1;
  end

  assign luse = id_valid & ex_memread & ex_regwr &
                (ex_wsel != '0) & rs_hit;

  always_comb begin
    pc_wen     = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_nx   = state;
    cnt_nx     = cnt;
    stall_inc  = 1'b0;
    if (RST || freeze) begin
      // everything held, outputs already zero
    end else if (redirect) begin
      // a redirect wins in every state and drops
      // any bubble sequence in progress
      pc_wen     = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nx = S_FLUSH;
        cnt_nx   = FL_LOAD;
      end else begin
        state_nx = S_RUN;
        cnt_nx   = '0;
      end
    end else begin
      case (state)
        S_LDSTALL: begin
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
          if (cnt == ONE) begin
            state_nx = S_RUN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt - ONE;
          end
        end
        S_FLUSH: begin
          pc_wen     = 1'b1;
          ifid_en    = 1'b1;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          ifid_flush = 1'b1;
          if (cnt == ONE) begin
            state_nx = S_RUN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt - ONE;
          end
        end
        default: begin
          state_nx = S_RUN;
          if (luse) begin
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
            if (LDUSE_BUBBLES > 1) begin
              state_nx = S_LDSTALL;
              cnt_nx   = LB_LOAD;
            end
          end else begin
            pc_wen   = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_RUN;
      cnt        <= '0;
      stall_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (freeze && freeze_cnt != '1)
        freeze_cnt <= freeze_cnt + 1'b1;
      if (stall_inc && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
